// File: rtl/load_store_unit.sv
// load_store_unit: initiator side of the core <-> data_memory load/store path.
// Accepts one request at a time over valid/ready and drives data_memory's
// address/mode/unsigned/data/write-enable inputs. It covers the memory's
// one-cycle registered read latency and returns load data with a
// one-cycle response strobe.
// Optional feature macro: LSU_MISALIGN_SPLIT_EN
//   defined   : misaligned accesses are split into byte beats.
//   undefined : misaligned requests are rejected with resp_misaligned.
// Mode encodings follow mem_modes.h: BYTE=0, HALF=1, WORD=2.
module load_store_unit (
    input  logic        clock,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [1:0]  req_mode,
    input  logic        req_unsigned,
    input  logic [31:0] req_address,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_misaligned,
    output logic [31:0] mem_address,
    output logic [1:0]  mem_mode,
    output logic        mem_unsigned,
    output logic [31:0] mem_data,
    output logic        mem_wren,
    input  logic [31:0] mem_q
);

    localparam logic [1:0] MEM_BYTE = 2'd0;
    localparam logic [1:0] MEM_HALF = 2'd1;
    localparam logic [1:0] MEM_WORD = 2'd2;

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_ISSUE    = 3'd1,
        S_WAIT     = 3'd2,
        S_ASSEMBLE = 3'd3,
        S_RESP     = 3'd4
    } state_t;

    // HALF on an odd address or WORD off a 4-byte boundary; BYTE never.
    function automatic logic f_misaligned(input logic [1:0] mode, input logic [31:0] addr);
        logic v_mis;
        case (mode)
            MEM_HALF: v_mis = addr[0];
            MEM_WORD: v_mis = (addr[1:0] != 2'b00);
            default:  v_mis = 1'b0;
        endcase
        return v_mis;
    endfunction

    // Index of the final beat: 0 for aligned, 1 for split HALF, 3 for split WORD.
    function automatic logic [1:0] f_last_beat(input logic split, input logic [1:0] mode);
        logic [1:0] v_last;
        if (!split) begin
            v_last = 2'd0;
        end else if (mode == MEM_HALF) begin
            v_last = 2'd1;
        end else begin
            v_last = 2'd3;
        end
        return v_last;
    endfunction

    // Replicate store data across the byte lanes so any lane data_memory picks is correct.
    function automatic logic [31:0] f_store_lanes(input logic [1:0] mode, input logic split,
                                                  input logic [1:0] beat, input logic [31:0] wdata);
        logic [7:0]  v_byte;
        logic [31:0] v_data;
        if (split) begin
            case (beat)
                2'd0:    v_byte = wdata[7:0];
                2'd1:    v_byte = wdata[15:8];
                2'd2:    v_byte = wdata[23:16];
                default: v_byte = wdata[31:24];
            endcase
            v_data = {4{v_byte}};
        end else begin
            case (mode)
                MEM_BYTE: v_data = {4{wdata[7:0]}};
                MEM_HALF: v_data = {2{wdata[15:0]}};
                default:  v_data = wdata;
            endcase
        end
        return v_data;
    endfunction

    // Place one returned byte into the little-endian assembly word.
    function automatic logic [31:0] f_insert_byte(input logic [31:0] acc, input logic [1:0] beat,
                                                  input logic [7:0] data);
        logic [31:0] v_acc;
        v_acc = acc;
        case (beat)
            2'd0:    v_acc[7:0]   = data;
            2'd1:    v_acc[15:8]  = data;
            2'd2:    v_acc[23:16] = data;
            default: v_acc[31:24] = data;
        endcase
        return v_acc;
    endfunction

    // Final extension of a split load; the byte beats themselves come back zero-extended.
    function automatic logic [31:0] f_extend(input logic [1:0] mode, input logic uns,
                                             input logic [31:0] acc);
        logic [31:0] v_res;
        if (mode == MEM_HALF) begin
            if (uns) begin
                v_res = {16'd0, acc[15:0]};
            end else begin
                v_res = {{16{acc[15]}}, acc[15:0]};
            end
        end else begin
            v_res = acc;
        end
        return v_res;
    endfunction

    state_t      r_state;
    state_t      w_state_next;

    logic        r_write;
    logic [1:0]  r_mode;
    logic        r_unsigned;
    logic [31:0] r_base;
    logic [31:0] r_wdata;
    logic        r_split;
    logic [1:0]  r_last;
    logic [1:0]  r_beat;
    logic [31:0] r_acc;

    logic [31:0] r_mem_address;
    logic [1:0]  r_mem_mode;
    logic        r_mem_unsigned;
    logic [31:0] r_mem_data;
    logic        r_mem_wren;
    logic        r_resp_valid;
    logic [31:0] r_resp_rdata;
    logic        r_resp_misaligned;

    logic        w_req_ready;
    logic        w_mis_req;
    logic        w_split_req;
    logic        w_reject_req;
    logic        w_capture;
    logic [1:0]  w_beat_inc;
    logic        w_last_beat;
    logic [31:0] w_beat_address;
    logic [1:0]  w_beat_next;
    logic [31:0] w_acc_next;
    logic [31:0] w_mem_address_next;
    logic [1:0]  w_mem_mode_next;
    logic        w_mem_unsigned_next;
    logic [31:0] w_mem_data_next;
    logic        w_mem_wren_next;
    logic        w_resp_valid_next;
    logic [31:0] w_resp_rdata_next;
    logic        w_resp_misaligned_next;

    assign w_req_ready    = (r_state == S_IDLE) && !reset;
    assign w_mis_req      = f_misaligned(req_mode, req_address);
    assign w_beat_inc     = r_beat + 2'd1;
    assign w_last_beat    = (r_beat == r_last);
    assign w_beat_address = r_base + {30'd0, w_beat_inc};

`ifdef LSU_MISALIGN_SPLIT_EN
    assign w_split_req  = w_mis_req;
    assign w_reject_req = 1'b0;
`else
    assign w_split_req  = 1'b0;
    assign w_reject_req = w_mis_req;
`endif

    // Next-state and next-output logic; outputs are loaded on the edge that enters each state.
    always_comb begin
        w_state_next           = r_state;
        w_capture              = 1'b0;
        w_beat_next            = r_beat;
        w_acc_next             = r_acc;
        w_mem_address_next     = r_mem_address;
        w_mem_mode_next        = r_mem_mode;
        w_mem_unsigned_next    = r_mem_unsigned;
        w_mem_data_next        = r_mem_data;
        w_mem_wren_next        = 1'b0;
        w_resp_valid_next      = 1'b0;
        w_resp_rdata_next      = 32'd0;
        w_resp_misaligned_next = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (req_valid && w_req_ready) begin
                    w_capture   = 1'b1;
                    w_beat_next = 2'd0;
                    w_acc_next  = 32'd0;
                    if (w_reject_req) begin
                        w_state_next           = S_RESP;
                        w_resp_valid_next      = 1'b1;
                        w_resp_misaligned_next = 1'b1;
                    end else begin
                        w_state_next        = S_ISSUE;
                        w_mem_address_next  = req_address;
                        w_mem_mode_next     = w_split_req ? MEM_BYTE : req_mode;
                        w_mem_unsigned_next = w_split_req ? 1'b1 : req_unsigned;
                        w_mem_data_next     = f_store_lanes(req_mode, w_split_req, 2'd0, req_wdata);
                        w_mem_wren_next     = req_write;
                    end
                end else begin
                    w_state_next = S_IDLE;
                end
            end
            S_ISSUE: begin
                if (r_write) begin
                    w_beat_next = w_beat_inc;
                    if (w_last_beat) begin
                        if (r_split) begin
                            w_state_next = S_ASSEMBLE;
                        end else begin
                            w_state_next      = S_RESP;
                            w_resp_valid_next = 1'b1;
                        end
                    end else begin
                        w_state_next       = S_ISSUE;
                        w_mem_address_next = w_beat_address;
                        w_mem_data_next    = f_store_lanes(r_mode, r_split, w_beat_inc, r_wdata);
                        w_mem_wren_next    = 1'b1;
                    end
                end else begin
                    w_state_next = S_WAIT;
                end
            end
            S_WAIT: begin
                w_beat_next = w_beat_inc;
                if (r_split) begin
                    w_acc_next = f_insert_byte(r_acc, r_beat, mem_q[7:0]);
                end else begin
                    w_acc_next = mem_q;
                end
                if (w_last_beat) begin
                    if (r_split) begin
                        w_state_next = S_ASSEMBLE;
                    end else begin
                        w_state_next      = S_RESP;
                        w_resp_valid_next = 1'b1;
                        w_resp_rdata_next = mem_q;
                    end
                end else begin
                    w_state_next       = S_ISSUE;
                    w_mem_address_next = w_beat_address;
                end
            end
            S_ASSEMBLE: begin
                w_state_next      = S_RESP;
                w_resp_valid_next = 1'b1;
                if (r_write) begin
                    w_resp_rdata_next = 32'd0;
                end else begin
                    w_resp_rdata_next = f_extend(r_mode, r_unsigned, r_acc);
                end
            end
            S_RESP: begin
                w_state_next = S_IDLE;
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Request latch so the core may change req_* after the handshake.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_write    <= 1'b0;
            r_mode     <= MEM_WORD;
            r_unsigned <= 1'b0;
            r_base     <= 32'd0;
            r_wdata    <= 32'd0;
            r_split    <= 1'b0;
            r_last     <= 2'd0;
        end else if (w_capture) begin
            r_write    <= req_write;
            r_mode     <= req_mode;
            r_unsigned <= req_unsigned;
            r_base     <= req_address;
            r_wdata    <= req_wdata;
            r_split    <= w_split_req;
            r_last     <= f_last_beat(w_split_req, req_mode);
        end else begin
            r_write    <= r_write;
        end
    end

    // Beat counter and load assembly word.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_beat <= 2'd0;
            r_acc  <= 32'd0;
        end else begin
            r_beat <= w_beat_next;
            r_acc  <= w_acc_next;
        end
    end

    // Registered memory-side and response outputs.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_mem_address     <= 32'd0;
            r_mem_mode        <= MEM_WORD;
            r_mem_unsigned    <= 1'b0;
            r_mem_data        <= 32'd0;
            r_mem_wren        <= 1'b0;
            r_resp_valid      <= 1'b0;
            r_resp_rdata      <= 32'd0;
            r_resp_misaligned <= 1'b0;
        end else begin
            r_mem_address     <= w_mem_address_next;
            r_mem_mode        <= w_mem_mode_next;
            r_mem_unsigned    <= w_mem_unsigned_next;
            r_mem_data        <= w_mem_data_next;
            r_mem_wren        <= w_mem_wren_next;
            r_resp_valid      <= w_resp_valid_next;
            r_resp_rdata      <= w_resp_rdata_next;
            r_resp_misaligned <= w_resp_misaligned_next;
        end
    end

    assign req_ready       = w_req_ready;
    assign resp_valid      = r_resp_valid;
    assign resp_rdata      = r_resp_rdata;
    assign resp_misaligned = r_resp_misaligned;
    assign mem_address     = r_mem_address;
    assign mem_mode        = r_mem_mode;
    assign mem_unsigned    = r_mem_unsigned;
    assign mem_data        = r_mem_data;
    assign mem_wren        = r_mem_wren;

endmodule

// File: doc/load_store_unit.md
# load_store_unit

Initiator side of the data-memory load/store interface, placed between the core's execute stage and `data_memory`. It accepts one load or store request at a time through a valid/ready handshake and drives `data_memory`'s address, mode, unsigned, data and write-enable inputs. It accounts for the memory's one-cycle registered read latency and returns load data through a response strobe. Misaligned accesses are split into byte accesses, so `data_memory` only ever sees naturally aligned accesses.

## Interface
- No parameters. Mode encodings MEM_BYTE, MEM_HALF and MEM_WORD come from `mem_modes.h`.
- `clock` input 1: the single clock; every register is clocked on its rising edge.
- `reset` input 1: asynchronous, active-high reset.
- `req_valid` input 1: the core presents a request.
- `req_ready` output 1: the unit accepts a request; high only in IDLE while `reset` is low.
- `req_write` input 1: 1 = store, 0 = load.
- `req_mode` input 2: access size (MEM_BYTE, MEM_HALF or MEM_WORD).
- `req_unsigned` input 1: 1 = zero-extend the load result.
- `req_address` input 32: byte address.
- `req_wdata` input 32: store data, right-aligned (size taken from bits [7:0], [15:0] or [31:0]).
- `resp_valid` output 1: one-cycle completion strobe, for loads and for stores.
- `resp_rdata` output 32: load result, valid while `resp_valid` is high; 0 for stores.
- `resp_misaligned` output 1: misaligned request rejected; only when the misalignment split is compiled out.
- `mem_address` output 32: address to `data_memory`.
- `mem_mode` output 2: mode to `data_memory`.
- `mem_unsigned` output 1: unsigned flag to `data_memory`.
- `mem_data` output 32: write data to `data_memory`.
- `mem_wren` output 1: write enable to `data_memory`.
- `mem_q` input 32: read data from `data_memory`; valid one cycle after the address is presented.

## Operation
- **Misaligned definition:** MEM_HALF with `address[0]`=1, or MEM_WORD with `address[1:0]`≠0. MEM_BYTE is never misaligned.
- **Request capture:** a handshake occurs when `req_valid` and `req_ready` are both high at a clock edge. The unit then latches all `req_*` inputs, so the core may change them afterwards.
- **Beat count:** set on acceptance.
  - Aligned access: 1 beat, issued with the request's own mode and unsigned flag.
  - Misaligned access: 2 beats for MEM_HALF, 4 beats for MEM_WORD.
  - Beat k addresses `base + k`, with 32-bit wrap-around.
  - Each beat is issued as MEM_BYTE with `mem_unsigned`=1.
- **States:**
  - IDLE: on a handshake, go to ISSUE.
  - ISSUE (store): `mem_wren`=1 for exactly one cycle, beat counter +1; if this was the last beat go to RESP, otherwise stay in ISSUE.
  - ISSUE (load): `mem_wren`=0; go to WAIT.
  - WAIT: capture `mem_q`, beat counter +1; if this was the last beat go to RESP, otherwise go to ISSUE.
  - RESP: `resp_valid`=1; go to IDLE.
- **Store data lanes:**
  - MEM_BYTE: `mem_data` = {4{byte}}.
  - Aligned MEM_HALF: `mem_data` = {2{wdata[15:0]}}.
  - MEM_WORD: `mem_data` = `wdata`.
  - Split beat k: `mem_data` = {4{wdata byte k}}, little-endian.
- **Load assembly:**
  - Aligned load: `resp_rdata` = `mem_q` as returned (`data_memory` has already shifted and extended it).
  - Split load: `mem_q[7:0]` of beat k goes to byte k. The result is then sign-extended from bit 15 (MEM_HALF) or used as-is (MEM_WORD); `req_unsigned` applies to MEM_HALF.
- **Signal stability:** `mem_address`, `mem_mode` and `mem_unsigned` hold their values through WAIT, because `data_memory` uses `mem_unsigned` combinationally.
- **Between accesses (IDLE and RESP):**
  - `mem_wren`=0.
  - `mem_address`, `mem_mode`, `mem_unsigned` and `mem_data` hold their last values.

## Timing
- **Reset values:**
  - State IDLE.
  - `resp_valid`, `resp_rdata`, `resp_misaligned` = 0.
  - `mem_wren`, `mem_address`, `mem_data`, `mem_unsigned` = 0.
  - `mem_mode` = MEM_WORD.
  - `req_ready` = 0 while `reset` is high.
- **Latency:** the handshake is at edge 0.

| Access | `resp_valid` cycle |
| --- | --- |
| Aligned store | 2 |
| Aligned load | 3 |
| Split store | 1 + N + 1 |
| Split load | 1 + 2N + 1 |

- **Throughput:** `req_ready` returns high in the cycle after RESP. The minimum request spacing is therefore 3 cycles for an aligned store and 4 cycles for an aligned load.
- **Requests while busy:** while `req_ready`=0 the unit ignores `req_valid`; nothing is queued and nothing is dropped silently, because the core must hold its request until the handshake.
- **Reset mid-operation:** asserting `reset` mid-access drops to IDLE immediately and forces `mem_wren` to 0. A partially written split store is not rolled back. No `resp_valid` is produced for the aborted request.

## Configuration
- **`LSU_MISALIGN_SPLIT_EN` defined:** misaligned accesses are split into byte beats as described above; `resp_misaligned` is tied to 0.
- **`LSU_MISALIGN_SPLIT_EN` undefined:** a misaligned request goes directly from IDLE to RESP with no memory access (`mem_wren` stays 0). It completes with `resp_valid`=1, `resp_misaligned`=1 and `resp_rdata`=0, 1 cycle after the handshake. Aligned behaviour is unchanged.

## Test plan
- Aligned MEM_WORD store of 0xDEADBEEF to 0x10, then a load from 0x10:
  - `mem_wren` is high for exactly one cycle, in cycle 1.
  - The load returns `resp_rdata`=0xDEADBEEF in cycle 3.
- MEM_BYTE signed load of 0x80 at address 0x13: `resp_rdata`=0xFFFFFF80. The same load with `req_unsigned`=1 returns 0x00000080.
- Split MEM_WORD store of 0x11223344 to 0x21 (split enabled):
  - 4 write beats at 0x21..0x24 with `mem_data` = 0x44444444, 0x33333333, 0x22222222, 0x11111111.
  - `resp_valid` in cycle 6.
  - A split load from 0x21 returns 0x11223344 in cycle 10.
- Split signed MEM_HALF load from 0x03 where the bytes are 0x34 (at 0x03) and 0xF2 (at 0x04): `resp_rdata`=0xFFFFF234.
- Split disabled, MEM_WORD load from 0x02: `resp_valid` and `resp_misaligned` are both 1 in cycle 1, with no `mem_wren` pulse.
- `reset` asserted during beat 2 of a split store:
  - `mem_wren` drops to 0 within the same cycle.
  - No `resp_valid` is produced.
  - `req_ready` is 1 in the first cycle after `reset` is released.
